// File: rtl/slc3_io_pkg.sv
// rtl/slc3_io_pkg.sv - shared types for the SLC-3 operator I/O responder
package slc3_io_pkg;

    localparam int LED_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_PRESS,
        WAIT_RELEASE,
        ACK,
        DONE
    } pause_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser, debouncer and edge strobes for one active-low pushbutton
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // the strobes are registered alongside it so they line up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b1;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (sync_lvl == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                level <= sync_lvl;
                press <= ~sync_lvl;
                rel   <= sync_lvl;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pause_continue_ctrl.sv
// rtl/pause_continue_ctrl.sv - Run start pulse and PAUSE/Continue handshake responder for the ISDU
module pause_continue_ctrl
    import slc3_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LED_W           = LED_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    input  logic             pause_req,
    input  logic [LED_W-1:0] pause_led,
    output logic             start_pulse,
    output logic             pause_ack,
    output logic             paused,
    output logic [LED_W-1:0] LED
);

    logic run_level, run_press, run_rel;
    logic cont_level, cont_press, cont_rel;
    logic abort;
    logic led_load;

    pause_state_t state_q, state_d;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk  (Clk),
        .rst_n(Reset),
        .btn_n(Run),
        .level(run_level),
        .press(run_press),
        .rel  (run_rel)
    );

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cont_db (
        .clk  (Clk),
        .rst_n(Reset),
        .btn_n(Continue),
        .level(cont_level),
        .press(cont_press),
        .rel  (cont_rel)
    );

    // Only the Run press strobe matters; its level and release are not needed here.
    logic unused_run;
    assign unused_run = &{1'b0, run_level, run_rel};

    assign start_pulse = run_press;
    assign abort       = ~pause_req | run_press;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            LED     <= '0;
        end else begin
            state_q <= state_d;
            if (led_load) begin
                LED <= pause_led;
            end
        end
    end

    // Abort is tested before progress in every pending state.
    always_comb begin
        state_d  = state_q;
        led_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (pause_req) begin
                    state_d  = ARM;
                    led_load = 1'b1;
                end
            end
            ARM: begin
                if (abort)           state_d = IDLE;
                else if (cont_level) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (abort)           state_d = IDLE;
                else if (cont_press) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (abort)         state_d = IDLE;
                else if (cont_rel) state_d = ACK;
            end
            ACK: begin
                state_d = DONE;
            end
            DONE: begin
                if (!pause_req) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pause_ack = (state_q == ACK);
    assign paused    = (state_q == ARM) || (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_pause_continue_ctrl.sv
// tb/tb_pause_continue_ctrl.sv - directed and randomized checks of pause_continue_ctrl against a behavioural model
module tb_pause_continue_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LW   = 10;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          run    = 1'b1;
    logic          cont   = 1'b1;
    logic          req    = 1'b0;
    logic [LW-1:0] led_in = '0;
    logic          start_pulse, pause_ack, paused;
    logic [LW-1:0] led;

    pause_continue_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LED_W          (LW)
    ) dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Run        (run),
        .Continue   (cont),
        .pause_req  (req),
        .pause_led  (led_in),
        .start_pulse(start_pulse),
        .pause_ack  (pause_ack),
        .paused     (paused),
        .LED        (led)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_ack    = 0;
    int last_ack = -1000;

    // Model: raw input history since reset, debounced levels, strobes, pause progress
    bit run_hist[$];
    bit cont_hist[$];
    bit m_run_lvl, m_cont_lvl, m_run_press, m_cont_press, m_cont_rel;
    bit m_pend, m_ack, m_done;
    int m_need;
    logic [LW-1:0] m_led;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        run_hist     = {};
        cont_hist    = {};
        m_run_lvl    = 1'b1;
        m_cont_lvl   = 1'b1;
        m_run_press  = 1'b0;
        m_cont_press = 1'b0;
        m_cont_rel   = 1'b0;
        m_pend       = 1'b0;
        m_ack        = 1'b0;
        m_done       = 1'b0;
        m_need       = 0;
        m_led        = '0;
    endtask

    // True when the last DEB synchronised samples all disagree with the current level.
    function automatic bit flips(input bit h[$], input bit lvl);
        int e;
        int j;
        bit s;
        e = h.size() - 1;
        for (int k = 0; k < DEB; k++) begin
            j = e - SYNC - k;
            s = (j >= 0) ? h[j] : 1'b1;
            if (s == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit p_run_press, p_cont_press, p_cont_rel, p_cont_lvl;
        p_run_press  = m_run_press;
        p_cont_press = m_cont_press;
        p_cont_rel   = m_cont_rel;
        p_cont_lvl   = m_cont_lvl;
        run_hist.push_back(run);
        cont_hist.push_back(cont);
        m_run_press  = 1'b0;
        m_cont_press = 1'b0;
        m_cont_rel   = 1'b0;
        if (flips(run_hist, m_run_lvl)) begin
            m_run_lvl   = !m_run_lvl;
            m_run_press = !m_run_lvl;
        end
        if (flips(cont_hist, m_cont_lvl)) begin
            m_cont_lvl   = !m_cont_lvl;
            m_cont_press = !m_cont_lvl;
            m_cont_rel   = m_cont_lvl;
        end
        if (m_ack) begin
            m_ack  = 1'b0;
            m_done = 1'b1;
        end else if (m_done) begin
            if (!req) m_done = 1'b0;
        end else if (m_pend) begin
            if (!req || p_run_press) m_pend = 1'b0;
            else if (m_need == 0) begin
                if (p_cont_lvl) m_need = 1;
            end else if (m_need == 1) begin
                if (p_cont_press) m_need = 2;
            end else if (p_cont_rel) begin
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end
        end else if (req) begin
            m_pend = 1'b1;
            m_need = 0;
            m_led  = led_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        cyc++;
        #1;
        chk("start_pulse", start_pulse, m_run_press);
        chk("pause_ack", pause_ack, m_ack);
        chk("paused", paused, m_pend);
        chk("LED", led, m_led);
        if (start_pulse) n_start++;
        if (pause_ack) begin
            chk("ack_spacing", (cyc - last_ack) >= 4, 1'b1);
            n_ack++;
            last_ack = cyc;
        end
    endtask

    initial begin
        int t0;
        int first;
        int got;
        logic [LW-1:0] held_led;

        model_reset();
        repeat (3) tick();
        chk("rst_start", start_pulse, 1'b0);
        chk("rst_ack", pause_ack, 1'b0);
        chk("rst_paused", paused, 1'b0);
        chk("rst_led", led, '0);
        rst_n = 1'b1;

        // 1: idle after reset
        n_start = 0;
        repeat (20) tick();
        chk("t1_no_start", n_start, 0);

        // 2: single Run press, latency 6
        n_start = 0; first = -1;
        run = 1'b0; t0 = cyc;
        repeat (10) begin
            tick();
            if (start_pulse && first < 0) first = cyc;
        end
        run = 1'b1;
        repeat (12) tick();
        chk("t2_start_count", n_start, 1);
        chk("t2_start_latency", first - t0, 6);

        // 3: normal pause with LED latch and ack latency 7
        req = 1'b1; led_in = 10'h05A;
        tick();
        chk("t3_led_latched", led, 10'h05A);
        chk("t3_paused", paused, 1'b1);
        repeat (3) tick();
        n_ack = 0; first = -1;
        cont = 1'b0;
        repeat (10) tick();
        cont = 1'b1; t0 = cyc;
        repeat (14) begin
            tick();
            if (pause_ack && first < 0) first = cyc;
        end
        chk("t3_ack_count", n_ack, 1);
        chk("t3_ack_latency", first - t0, 7);
        req = 1'b0;
        repeat (3) tick();
        chk("t3_unpaused", paused, 1'b0);
        chk("t3_led_held", led, 10'h05A);

        // 4: Continue held from before the pause is not counted
        cont = 1'b0;
        repeat (12) tick();
        led_in = 10'h001; req = 1'b1; n_ack = 0;
        repeat (10) tick();
        chk("t4_no_ack_held", n_ack, 0);
        chk("t4_paused_held", paused, 1'b1);
        cont = 1'b1;
        repeat (10) tick();
        cont = 1'b0;
        repeat (10) tick();
        cont = 1'b1;
        repeat (12) tick();
        chk("t4_ack_count", n_ack, 1);
        chk("t4_led", led, 10'h001);
        req = 1'b0;
        repeat (3) tick();

        // 5: glitch on Continue while waiting for the press
        req = 1'b1; led_in = LW'($urandom); held_led = led_in;
        repeat (4) tick();
        n_ack = 0;
        cont = 1'b0;
        repeat (2) tick();
        cont = 1'b1;
        repeat (12) tick();
        chk("t5_paused", paused, 1'b1);
        chk("t5_no_ack", n_ack, 0);

        // 6: Run press aborts the pending pause
        n_start = 0; got = 0;
        led_in = ~held_led;
        run = 1'b0;
        repeat (10) begin
            tick();
            if (got == 1) begin
                chk("t6_paused_cleared", paused, 1'b0);
                chk("t6_led_kept", led, held_led);
                got = 2;
            end
            if (start_pulse && got == 0) got = 1;
        end
        run = 1'b1;
        req = 1'b0;
        repeat (10) tick();
        chk("t6_start_count", n_start, 1);
        chk("t6_no_ack", n_ack, 0);
        chk("t6_abort_seen", got, 2);

        // Randomized traffic with an ISDU-like requester
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(7) == 0) run = ~run;
            if ($urandom_range(5) == 0) cont = ~cont;
            if (!req) begin
                if ($urandom_range(9) == 0) begin
                    req = 1'b1;
                    led_in = LW'($urandom);
                end
            end else if (pause_ack || $urandom_range(79) == 0) begin
                req = 1'b0;
            end
            tick();
        end
        run = 1'b1; cont = 1'b1; req = 1'b0;
        repeat (12) tick();

        // Reset in the middle of a pause
        req = 1'b1; led_in = 10'h3C3;
        repeat (4) tick();
        cont = 1'b0;
        repeat (8) tick();
        cont = 1'b1;
        repeat (2) tick();
        chk("rst_mid_paused_before", paused, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_paused", paused, 1'b0);
        chk("rst_mid_ack", pause_ack, 1'b0);
        chk("rst_mid_led", led, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_ack = 0;
        repeat (20) tick();
        chk("rst_mid_no_ack", n_ack, 0);
        req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pause_continue_ctrl.md
Name: pause_continue_ctrl

Overview:
Operator-side responder for the SLC-3 Run/Continue protocol. It synchronises and debounces the active-low Run and Continue pushbuttons and turns a Run press into a one-cycle start pulse for the ISDU. It also serves the ISDU's PAUSE handshake: it latches the pause LED value and acknowledges only after a full Continue press-and-release. It sits between the board buttons/LEDs and the ISDU inside slc3.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each button synchroniser (minimum 2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the debounced level changes (minimum 1)
LED_W, 10, width of the pause LED field

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-low reset
Run  in  1  raw Run pushbutton, active-low (0 = pressed)
Continue  in  1  raw Continue pushbutton, active-low (0 = pressed)
pause_req  in  1  from ISDU; held high while the ISDU sits in a PAUSE state
pause_led  in  LED_W  LED value for this pause (IR[9:0]); valid while pause_req is high
start_pulse  out  1  one-cycle pulse on each debounced Run press
pause_ack  out  1  one-cycle pulse that releases the ISDU from PAUSE
paused  out  1  high while a pause is pending, i.e. in states ARM, WAIT_PRESS or WAIT_RELEASE
LED  out  LED_W  registered LED drive

Behaviour:
- Reset (Reset=0, asynchronous): sync chains load 1 (released); debounced levels = released; debounce counters = 0; FSM = IDLE; start_pulse=0, pause_ack=0, paused=0, LED=0.
- Debounce, per button: each button has its own DEBOUNCE_CYCLES counter.
  - Synchronised level equal to debounced level: counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Latency from a raw edge to the debounced edge is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- Press/release events are single-cycle strobes derived from debounced edges (falling = press, rising = release).
- start_pulse = registered Run press strobe, exactly 1 cycle per press. Holding Run produces no repeat pulses. Independent of the FSM.
- Pause FSM, one-hot or encoded at implementer's choice:
  - IDLE: pause_req=1 -> latch LED<=pause_led; go ARM.
  - ARM: Continue debounced released -> WAIT_PRESS. This guarantees that a Continue held from before the pause is never counted.
  - WAIT_PRESS: Continue press strobe -> WAIT_RELEASE.
  - WAIT_RELEASE: Continue release strobe -> ACK.
  - ACK: pause_ack=1 for this single cycle -> DONE.
  - DONE: wait for pause_req=0 -> IDLE. The ISDU drops pause_req after seeing the ack.
- Abort rules:
  - pause_req=0 in ARM, WAIT_PRESS or WAIT_RELEASE -> IDLE, no ack.
  - A Run press strobe in ARM, WAIT_PRESS or WAIT_RELEASE -> IDLE, no ack; start_pulse is still issued.
  - Abort takes priority over progress when both occur in the same cycle.
- LED holds its latched value after ack or abort, until the next IDLE->ARM latch or reset.
- Continue press/release strobes in IDLE, ACK or DONE are discarded.
- pause_ack never asserts on two consecutive cycles. Minimum spacing between acks is 4 cycles.
- Reset asserted mid-pause: FSM returns to IDLE immediately, and no ack is emitted after reset releases.

Decomposition:
- Package slc3_io_pkg holds:
  - typedef enum pause_state_t {IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, ACK, DONE};
  - localparam LED_W_DEFAULT=10.
- Sub-module btn_debounce, instantiated twice (Run, Continue), parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. Outputs: level, press, release.

Test Plan:
1. Reset=0 then 1, buttons released -> all outputs 0, FSM IDLE, no start_pulse for 20 cycles.
2. Run low for 10 cycles then high -> exactly one start_pulse, asserted 6 cycles after the falling edge (defaults); none on release.
3. pause_req=1, pause_led=10'h05A; Continue low 10 cycles then high -> LED=10'h05A one cycle after the req edge; paused=1 until ack; pause_ack single pulse 7 cycles after the Continue rising edge (6 debounce/sync + 1 ACK state); drop req -> IDLE.
4. Continue held low before pause_req=1 with pause_led=10'h001 -> no ack while held; release, then a full press/release -> exactly one ack; LED=10'h001.
5. Continue pulses low for 2 cycles (glitch) during WAIT_PRESS -> no state change, no ack.
6. Pause pending, Run pressed -> start_pulse=1 once, FSM IDLE, paused=0, no pause_ack; LED retains latched value.
